// File: rtl/rename_dispatch_nway.sv
// rename_dispatch_nway: N-wide in-order rename/dispatch with intra-group RAW/WAW resolution.
// Optional stall/dispatch counters are compiled in with RENAME_DISPATCH_STATS_EN.
module rename_dispatch_nway #(
   parameter int DISPATCH_WIDTH = 2,
   parameter int ARCH_REG_BITS  = 5,
   parameter int PHYS_REG_BITS  = 6,
   parameter int ROB_ADDR_WIDTH = 5,
   parameter int CNT_BITS       = 3
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      flush,
   input  logic [DISPATCH_WIDTH-1:0]                 iq_valid,
   input  logic [32*DISPATCH_WIDTH-1:0]              iq_inst,
   input  logic [32*DISPATCH_WIDTH-1:0]              iq_pc,
   output logic [CNT_BITS-1:0]                       iq_deq_cnt,
   input  logic [PHYS_REG_BITS*DISPATCH_WIDTH-1:0]   fl_preg,
   input  logic [CNT_BITS-1:0]                       fl_count,
   output logic [CNT_BITS-1:0]                       fl_deq_cnt,
   input  logic [CNT_BITS-1:0]                       rob_free_cnt,
   input  logic [ROB_ADDR_WIDTH-1:0]                 rob_tail,
   input  logic [5*CNT_BITS-1:0]                     rs_free_cnt,
   output logic [ARCH_REG_BITS*DISPATCH_WIDTH-1:0]   rat_rs1,
   output logic [ARCH_REG_BITS*DISPATCH_WIDTH-1:0]   rat_rs2,
   input  logic [PHYS_REG_BITS*DISPATCH_WIDTH-1:0]   rat_ps1,
   input  logic [PHYS_REG_BITS*DISPATCH_WIDTH-1:0]   rat_ps2,
   input  logic [DISPATCH_WIDTH-1:0]                 rat_ps1_valid,
   input  logic [DISPATCH_WIDTH-1:0]                 rat_ps2_valid,
   output logic [DISPATCH_WIDTH-1:0]                 rat_we,
   output logic [ARCH_REG_BITS*DISPATCH_WIDTH-1:0]   rat_rd,
   output logic [PHYS_REG_BITS*DISPATCH_WIDTH-1:0]   rat_pd,
   output logic [DISPATCH_WIDTH-1:0]                 disp_valid,
   output logic [32*DISPATCH_WIDTH-1:0]              disp_inst,
   output logic [32*DISPATCH_WIDTH-1:0]              disp_pc,
   output logic [PHYS_REG_BITS*DISPATCH_WIDTH-1:0]   disp_pd,
   output logic [PHYS_REG_BITS*DISPATCH_WIDTH-1:0]   disp_ps1,
   output logic [PHYS_REG_BITS*DISPATCH_WIDTH-1:0]   disp_ps2,
   output logic [DISPATCH_WIDTH-1:0]                 disp_ps1_valid,
   output logic [DISPATCH_WIDTH-1:0]                 disp_ps2_valid,
   output logic [ROB_ADDR_WIDTH*DISPATCH_WIDTH-1:0]  disp_rob_idx,
   output logic [3*DISPATCH_WIDTH-1:0]               disp_rs_class
`ifdef RENAME_DISPATCH_STATS_EN
   ,
   output logic [31:0]                               stall_fl,
   output logic [31:0]                               stall_rob,
   output logic [31:0]                               stall_rs,
   output logic [31:0]                               dispatched
`endif
);
   localparam int W = DISPATCH_WIDTH;
   localparam int A = ARCH_REG_BITS;
   localparam int P = PHYS_REG_BITS;
   localparam int R = ROB_ADDR_WIDTH;
   localparam int C = CNT_BITS;

   typedef struct packed {
      logic [31:0]  inst;
      logic [31:0]  pc;
      logic [P-1:0] pd;
      logic [P-1:0] ps1;
      logic [P-1:0] ps2;
      logic         v1;
      logic         v2;
      logic [R-1:0] rob;
      logic [2:0]   cls;
   } pkt_t;

   function automatic logic [2:0] cls_of(input logic [31:0] i);
      return (i[6:0] == 7'b0110011 && i[31:25] == 7'b0000001) ? (i[14] ? 3'd2 : 3'd1) :
             (i[6:0] == 7'b1101111 || i[6:0] == 7'b1100111 || i[6:0] == 7'b1100011) ? 3'd3 :
             (i[6:0] == 7'b0000011 || i[6:0] == 7'b0100011) ? 3'd4 : 3'd0;
   endfunction

   logic [31:0]  inst [W];
   logic [A-1:0] rd [W], rs1 [W], rs2 [W];
   logic [2:0]   cls [W];
   logic [P-1:0] flp [W], rp1 [W], rp2 [W], pd [W], ps1 [W], ps2 [W];
   logic [C-1:0] rsf [5];
   logic [W-1:0] need, acc, we, v1, v2, vld_q;
   logic [C-1:0] n_acc, n_dst;
   logic [C-1:0] n_cls [5];
   logic         ok, kill;
   pkt_t         pkt_d [W], pkt_q [W];

   assign kill = flush | rst;

   for (genvar c = 0; c < 5; c++) begin : g_rs
      assign rsf[c] = rs_free_cnt[C*c +: C];
   end

   for (genvar k = 0; k < W; k++) begin : g_lane
      assign inst[k] = iq_inst[32*k +: 32];
      assign rd[k]   = A'(inst[k][11:7]);
      assign rs1[k]  = A'(inst[k][19:15]);
      assign rs2[k]  = A'(inst[k][24:20]);
      assign cls[k]  = cls_of(inst[k]);
      assign need[k] = rd[k] != '0 && inst[k][6:0] != 7'b1100011 && inst[k][6:0] != 7'b0100011;
      assign flp[k]  = fl_preg[P*k +: P];
      assign rp1[k]  = rat_ps1[P*k +: P];
      assign rp2[k]  = rat_ps2[P*k +: P];
      assign rat_rs1[A*k +: A] = kill ? '0 : rs1[k];
      assign rat_rs2[A*k +: A] = kill ? '0 : rs2[k];
      assign rat_rd[A*k +: A]  = we[k] ? rd[k] : '0;
      assign rat_pd[P*k +: P]  = we[k] ? pd[k] : '0;
      assign pkt_d[k] = '{inst: inst[k], pc: iq_pc[32*k +: 32], pd: pd[k], ps1: ps1[k], ps2: ps2[k],
                          v1: v1[k], v2: v2[k], rob: rob_tail + R'(k), cls: cls[k]};
      assign disp_inst[32*k +: 32]  = pkt_q[k].inst;
      assign disp_pc[32*k +: 32]    = pkt_q[k].pc;
      assign disp_pd[P*k +: P]      = pkt_q[k].pd;
      assign disp_ps1[P*k +: P]     = pkt_q[k].ps1;
      assign disp_ps2[P*k +: P]     = pkt_q[k].ps2;
      assign disp_ps1_valid[k]      = pkt_q[k].v1;
      assign disp_ps2_valid[k]      = pkt_q[k].v2;
      assign disp_rob_idx[R*k +: R] = pkt_q[k].rob;
      assign disp_rs_class[3*k +: 3] = pkt_q[k].cls;
   end

   // In-order acceptance: each lane must fit into the resources left after all earlier lanes.
   always_comb begin
      acc = '0;
      pd = '{default: '0};
      n_acc = '0;
      n_dst = '0;
      n_cls = '{default: '0};
      ok = !kill;
      for (int k = 0; k < W; k++) begin
         ok = ok && iq_valid[k] && ({1'b0, n_dst} + (C+1)'(need[k])) <= {1'b0, fl_count} &&
              ({1'b0, n_acc} + 1'b1) <= {1'b0, rob_free_cnt} &&
              ({1'b0, n_cls[cls[k]]} + 1'b1) <= {1'b0, rsf[cls[k]]};
         acc[k] = ok;
         for (int j = 0; j < W; j++)
            if (ok && need[k] && n_dst == C'(j)) pd[k] = flp[j];
         if (ok) begin
            n_acc = n_acc + 1'b1;
            n_dst = n_dst + C'(need[k]);
            n_cls[cls[k]] = n_cls[cls[k]] + 1'b1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < W; k++) begin
         ps1[k] = rs1[k] == '0 ? '0 : rp1[k];
         ps2[k] = rs2[k] == '0 ? '0 : rp2[k];
         v1[k] = rs1[k] == '0 || rat_ps1_valid[k];
         v2[k] = rs2[k] == '0 || rat_ps2_valid[k];
         we[k] = acc[k] && need[k];
         for (int j = 0; j < W; j++) begin
            if (j < k && acc[j] && need[j] && rs1[k] != '0 && rd[j] == rs1[k]) begin
               ps1[k] = pd[j];
               v1[k] = 1'b0;
            end
            if (j < k && acc[j] && need[j] && rs2[k] != '0 && rd[j] == rs2[k]) begin
               ps2[k] = pd[j];
               v2[k] = 1'b0;
            end
            if (j > k && acc[j] && need[j] && rd[j] == rd[k]) we[k] = 1'b0;
         end
      end
   end

   assign iq_deq_cnt = n_acc;
   assign fl_deq_cnt = n_dst;
   assign rat_we     = we;
   assign disp_valid = vld_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         pkt_q <= '{default: '0};
      end else begin
         vld_q <= acc;
         pkt_q <= pkt_d;
      end
   end

`ifdef RENAME_DISPATCH_STATS_EN
   logic [31:0] sfl_q, srob_q, srs_q, disp_q;
   logic        f0, r0, s0, st0;
   assign f0  = need[0] && fl_count == '0;
   assign r0  = rob_free_cnt == '0;
   assign s0  = rsf[cls[0]] == '0;
   assign st0 = iq_valid[0] && !acc[0];
   always_ff @(posedge clk) begin
      if (rst) begin
         sfl_q  <= '0;
         srob_q <= '0;
         srs_q  <= '0;
         disp_q <= '0;
      end else begin
         sfl_q  <= sfl_q + 32'(st0 && f0);
         srob_q <= srob_q + 32'(st0 && !f0 && r0);
         srs_q  <= srs_q + 32'(st0 && !f0 && !r0 && s0);
         disp_q <= disp_q + 32'(iq_deq_cnt);
      end
   end
   assign stall_fl   = sfl_q;
   assign stall_rob  = srob_q;
   assign stall_rs   = srs_q;
   assign dispatched = disp_q;
`endif
endmodule

// File: tb/tb_rename_dispatch_nway.sv
// tb_rename_dispatch_nway: randomized scoreboard bench for rename_dispatch_nway (W=2).
module tb_rename_dispatch_nway;
   localparam int W = 2, A = 5, P = 6, R = 5, C = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, flush;
   logic [W-1:0] iq_valid, rat_ps1_valid, rat_ps2_valid, rat_we, disp_valid, disp_ps1_valid, disp_ps2_valid;
   logic [32*W-1:0] iq_inst, iq_pc, disp_inst, disp_pc;
   logic [C-1:0] iq_deq_cnt, fl_count, fl_deq_cnt, rob_free_cnt;
   logic [P*W-1:0] fl_preg, rat_ps1, rat_ps2, rat_pd, disp_pd, disp_ps1, disp_ps2;
   logic [R-1:0] rob_tail;
   logic [5*C-1:0] rs_free_cnt;
   logic [A*W-1:0] rat_rs1, rat_rs2, rat_rd;
   logic [R*W-1:0] disp_rob_idx;
   logic [3*W-1:0] disp_rs_class;

   rename_dispatch_nway #(.DISPATCH_WIDTH(W), .ARCH_REG_BITS(A), .PHYS_REG_BITS(P),
                          .ROB_ADDR_WIDTH(R), .CNT_BITS(C)) dut (
      .clk(clk), .rst(rst), .flush(flush), .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
      .iq_deq_cnt(iq_deq_cnt), .fl_preg(fl_preg), .fl_count(fl_count), .fl_deq_cnt(fl_deq_cnt),
      .rob_free_cnt(rob_free_cnt), .rob_tail(rob_tail), .rs_free_cnt(rs_free_cnt),
      .rat_rs1(rat_rs1), .rat_rs2(rat_rs2), .rat_ps1(rat_ps1), .rat_ps2(rat_ps2),
      .rat_ps1_valid(rat_ps1_valid), .rat_ps2_valid(rat_ps2_valid), .rat_we(rat_we),
      .rat_rd(rat_rd), .rat_pd(rat_pd), .disp_valid(disp_valid), .disp_inst(disp_inst),
      .disp_pc(disp_pc), .disp_pd(disp_pd), .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
      .disp_ps1_valid(disp_ps1_valid), .disp_ps2_valid(disp_ps2_valid),
      .disp_rob_idx(disp_rob_idx), .disp_rs_class(disp_rs_class));

   logic [P-1:0] rat_tbl [32];
   logic [31:0]  rat_rdy;

   always_comb begin
      rat_ps1 = '0;
      rat_ps2 = '0;
      rat_ps1_valid = '0;
      rat_ps2_valid = '0;
      for (int k = 0; k < W; k++) begin
         rat_ps1[k*P +: P] = rat_tbl[rat_rs1[k*A +: A]];
         rat_ps2[k*P +: P] = rat_tbl[rat_rs2[k*A +: A]];
         rat_ps1_valid[k]  = rat_rdy[rat_rs1[k*A +: A]];
         rat_ps2_valid[k]  = rat_rdy[rat_rs2[k*A +: A]];
      end
   end

   typedef struct packed {
      logic [C-1:0]          deq, fdq;
      logic [W-1:0]          we, vld, v1, v2;
      logic [W-1:0][A-1:0]   wrd;
      logic [W-1:0][P-1:0]   wpd, pd, ps1, ps2;
      logic [W-1:0][31:0]    inst, pc;
      logic [W-1:0][R-1:0]   rob;
      logic [W-1:0][2:0]     cls;
      logic                  in_rst;
   } exp_t;

   exp_t q[$];
   int checks = 0, errors = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] cls_m(input logic [31:0] i);
      case (i[6:0])
         7'b0110011: return i[31:25] == 7'b0000001 ? (i[14] ? 3'd2 : 3'd1) : 3'd0;
         7'b1101111, 7'b1100111, 7'b1100011: return 3'd3;
         7'b0000011, 7'b0100011: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   // Reference: walk lanes in order spending remaining resources; a group map tracks in-flight renames.
   task automatic issue();
      exp_t e;
      int fl_rem, rob_rem, nxt;
      int rs_rem [5];
      logic [P-1:0] gmap [32];
      bit ghas [32];
      int last [32];
      e = '0;
      fl_rem = int'(fl_count);
      rob_rem = int'(rob_free_cnt);
      for (int c = 0; c < 5; c++) rs_rem[c] = int'(rs_free_cnt[c*C +: C]);
      for (int r = 0; r < 32; r++) begin
         ghas[r] = 0;
         last[r] = -1;
         gmap[r] = '0;
      end
      nxt = 0;
      for (int k = 0; k < W; k++) begin
         logic [31:0] i;
         logic [2:0] c;
         bit nd;
         int d, s1, s2;
         i = iq_inst[k*32 +: 32];
         c = cls_m(i);
         d = int'(i[11:7]);
         s1 = int'(i[19:15]);
         s2 = int'(i[24:20]);
         nd = d != 0 && i[6:0] != 7'b1100011 && i[6:0] != 7'b0100011;
         if (rst || flush || !iq_valid[k] || (nd && fl_rem == 0) || rob_rem == 0 || rs_rem[c] == 0) break;
         e.vld[k] = 1'b1;
         e.deq = e.deq + 1'b1;
         rob_rem--;
         rs_rem[c]--;
         e.inst[k] = i;
         e.pc[k] = iq_pc[k*32 +: 32];
         e.cls[k] = c;
         e.rob[k] = rob_tail + R'(k);
         e.ps1[k] = s1 == 0 ? '0 : ghas[s1] ? gmap[s1] : rat_tbl[s1];
         e.v1[k]  = s1 == 0 ? 1'b1 : ghas[s1] ? 1'b0 : rat_rdy[s1];
         e.ps2[k] = s2 == 0 ? '0 : ghas[s2] ? gmap[s2] : rat_tbl[s2];
         e.v2[k]  = s2 == 0 ? 1'b1 : ghas[s2] ? 1'b0 : rat_rdy[s2];
         if (nd) begin
            e.pd[k] = fl_preg[nxt*P +: P];
            nxt++;
            fl_rem--;
            gmap[d] = e.pd[k];
            ghas[d] = 1;
            last[d] = k;
         end
      end
      e.fdq = C'(nxt);
      for (int k = 0; k < W; k++) begin
         int d;
         d = int'(iq_inst[k*32+7 +: 5]);
         if (e.vld[k] && ghas[d] && last[d] == k) begin
            e.we[k] = 1'b1;
            e.wrd[k] = A'(d);
            e.wpd[k] = e.pd[k];
         end
      end
      e.in_rst = rst;
      q.push_back(e);
   endtask

   initial begin
      exp_t cur, prev;
      bit have_prev;
      have_prev = 0;
      forever begin
         @(negedge clk);
         if (have_prev) begin
            if (prev.in_rst) begin
               check("rst_disp_valid", 64'(disp_valid), 64'd0);
               check("rst_disp_inst", 64'(disp_inst), 64'd0);
               check("rst_disp_pd", 64'(disp_pd), 64'd0);
               check("rst_disp_rob", 64'(disp_rob_idx), 64'd0);
            end else begin
               check("disp_valid", 64'(disp_valid), 64'(prev.vld));
               for (int k = 0; k < W; k++) if (prev.vld[k]) begin
                  check("disp_inst", 64'(disp_inst[k*32 +: 32]), 64'(prev.inst[k]));
                  check("disp_pc", 64'(disp_pc[k*32 +: 32]), 64'(prev.pc[k]));
                  check("disp_pd", 64'(disp_pd[k*P +: P]), 64'(prev.pd[k]));
                  check("disp_ps1", 64'(disp_ps1[k*P +: P]), 64'(prev.ps1[k]));
                  check("disp_ps2", 64'(disp_ps2[k*P +: P]), 64'(prev.ps2[k]));
                  check("disp_ps1_valid", 64'(disp_ps1_valid[k]), 64'(prev.v1[k]));
                  check("disp_ps2_valid", 64'(disp_ps2_valid[k]), 64'(prev.v2[k]));
                  check("disp_rob_idx", 64'(disp_rob_idx[k*R +: R]), 64'(prev.rob[k]));
                  check("disp_rs_class", 64'(disp_rs_class[k*3 +: 3]), 64'(prev.cls[k]));
               end
            end
         end
         have_prev = 0;
         if (q.size() != 0) begin
            cur = q.pop_front();
            check("iq_deq_cnt", 64'(iq_deq_cnt), 64'(cur.deq));
            check("fl_deq_cnt", 64'(fl_deq_cnt), 64'(cur.fdq));
            check("rat_we", 64'(rat_we), 64'(cur.we));
            for (int k = 0; k < W; k++) if (cur.we[k]) begin
               check("rat_rd", 64'(rat_rd[k*A +: A]), 64'(cur.wrd[k]));
               check("rat_pd", 64'(rat_pd[k*P +: P]), 64'(cur.wpd[k]));
            end
            prev = cur;
            have_prev = 1;
         end
      end
   end

   function automatic logic [31:0] rt(input logic [6:0] f7, input int s2, input int s1,
                                      input logic [2:0] f3, input int d, input logic [6:0] op);
      return {f7, 5'(s2), 5'(s1), f3, 5'(d), op};
   endfunction

   function automatic logic [31:0] rand_inst();
      int d, s1, s2;
      d = $urandom_range(0, 5);
      s1 = $urandom_range(0, 5);
      s2 = $urandom_range(0, 5);
      case ($urandom_range(0, 8))
         0: return rt(7'd0, s2, s1, 3'd0, d, 7'b0110011);
         1: return rt(7'd1, s2, s1, 3'($urandom_range(0, 3)), d, 7'b0110011);
         2: return rt(7'd1, s2, s1, 3'($urandom_range(4, 7)), d, 7'b0110011);
         3: return rt(7'($urandom), s2, s1, 3'd0, d, 7'b0010011);
         4: return rt(7'($urandom), s2, s1, 3'd2, d, 7'b0000011);
         5: return rt(7'd0, s2, s1, 3'd2, d, 7'b0100011);
         6: return rt(7'd0, s2, s1, 3'd0, d, 7'b1100011);
         7: return rt(7'($urandom), s2, s1, 3'($urandom), d, 7'b1101111);
         default: return rt(7'($urandom), s2, s1, 3'd0, d, 7'b1100111);
      endcase
   endfunction

   task automatic ample();
      rst = 0;
      flush = 0;
      fl_count = 3'd7;
      rob_free_cnt = 3'd7;
      rs_free_cnt = {5{3'd7}};
      fl_preg = {6'd11, 6'd10};
      rob_tail = '0;
      iq_pc = {32'h104, 32'h100};
      iq_valid = 2'b11;
      iq_inst = {rt(7'd0, 1, 3, 3'd0, 4, 7'b0110011), rt(7'd0, 2, 1, 3'd0, 3, 7'b0110011)};
   endtask

   task automatic step();
      issue();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int r = 0; r < 32; r++) rat_tbl[r] = P'($urandom);
      rat_rdy = $urandom;
      rat_tbl[1] = 6'd5;
      rat_rdy[1] = 1'b1;
      ample();
      rst = 1;
      @(posedge clk);
      #1;
      step();
      ample();
      step();
      ample();
      fl_count = 3'd1;
      step();
      ample();
      fl_count = 3'd0;
      iq_inst = {rt(7'd0, 2, 1, 3'd2, 0, 7'b0100011), rt(7'd0, 2, 1, 3'd0, 8, 7'b1100011)};
      step();
      ample();
      rs_free_cnt = {3'd7, 3'd7, 3'd7, 3'd1, 3'd7};
      iq_inst = {rt(7'd1, 4, 3, 3'd0, 6, 7'b0110011), rt(7'd1, 2, 1, 3'd0, 5, 7'b0110011)};
      step();
      iq_valid = 2'b01;
      iq_inst[31:0] = rt(7'd1, 4, 3, 3'd0, 6, 7'b0110011);
      step();
      ample();
      rob_tail = 5'd31;
      step();
      ample();
      flush = 1;
      step();
      ample();
      step();
      ample();
      rst = 1;
      step();
      for (int n = 0; n < 800; n++) begin
         int v;
         v = $urandom_range(0, W);
         iq_valid = W'((1 << v) - 1);
         for (int k = 0; k < W; k++) begin
            iq_inst[k*32 +: 32] = rand_inst();
            iq_pc[k*32 +: 32] = $urandom;
            fl_preg[k*P +: P] = P'($urandom_range(1, 63));
         end
         fl_count = ($urandom_range(0, 2) == 0) ? C'($urandom_range(0, 2)) : C'($urandom);
         rob_free_cnt = ($urandom_range(0, 3) == 0) ? C'($urandom_range(0, 2)) : 3'd7;
         for (int c = 0; c < 5; c++)
            rs_free_cnt[c*C +: C] = ($urandom_range(0, 3) == 0) ? C'($urandom_range(0, 2)) : C'($urandom);
         rob_tail = R'($urandom);
         flush = ($urandom_range(0, 15) == 0);
         rst = ($urandom_range(0, 39) == 0);
         rat_tbl[$urandom_range(0, 31)] = P'($urandom);
         rat_rdy[$urandom_range(0, 31)] = 1'($urandom);
         step();
      end
      ample();
      iq_valid = '0;
      repeat (2) step();
      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
